wb_stage: RTL and testbench

//   Writeback stage of the pipelined RV32I core; sits between MEM and the register file write port.
//   - Holds the MEM/WB pipeline register.
//   - Waits for load data from data memory (which has variable latency).
//   - Extracts and extends sub-word load data.
//   - Drives the register file write port plus a same-cycle forwarding port to decode.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/load_ext.sv | 30 +++
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Load funct3 encodings, FSM state type, latched load context.
package wb_pkg;

  localparam int WB_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {IDLE, WAIT_LD} wb_state_t;

  // Everything needed to finish a load once dmem answers.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic                 we;
    logic [2:0]           funct3;
    logic [1:0]           addr_lo;
  } load_ctx_t;

endpackage

// File: rtl/load_ext.sv
// Sub-word load extraction: picks the byte/half addressed by addr_lo
// out of an aligned word and sign- or zero-extends it.
import wb_pkg::*;

module load_ext #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to funct3.
  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
    case (funct3)
      F3_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load wait, register-file write
// and same-cycle forward port. Optional retired-instruction counter is
// built when WB_INSTRET_EN is defined; otherwise instret reads 0.
// Handshake: an instruction transfers on a cycle where m_valid & m_ready;
// MEM holds its inputs stable while m_valid is high and m_ready is low.
// When a load completes in the same cycle an ALU op fires, the load is
// written first and the ALU op is parked one cycle in a pending slot.
import wb_pkg::*;

module wb_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_rd,
  input  logic              m_we,
  input  logic              m_is_load,
  input  logic [2:0]        m_funct3,
  input  logic [1:0]        m_addr_lo,
  input  logic [DATA_W-1:0] m_alu_res,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [63:0]       instret,
  output wb_state_t         dbg_state
);

  wb_state_t         state_q, state_d;
  load_ctx_t         ctx_q;
  logic              fire, alu_fire, ld_fire, load_done;
  logic              wr_en_d, pend_take;
  logic [ADDR_W-1:0] wr_rd_d;
  logic [DATA_W-1:0] wr_data_d, ld_data;
  logic              pend_v_q, pend_we_q;
  logic [ADDR_W-1:0] pend_rd_q;
  logic [DATA_W-1:0] pend_data_q;

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .funct3  (ctx_q.funct3),
    .addr_lo (ctx_q.addr_lo),
    .word    (dmem_rdata),
    .data    (ld_data)
  );

  // Handshake decode and next-state selection.
  always_comb begin
    m_ready   = (state_q == IDLE) | dmem_rvalid;
    fire      = m_valid & m_ready;
    alu_fire  = fire & ~m_is_load;
    ld_fire   = fire & m_is_load;
    load_done = (state_q == WAIT_LD) & dmem_rvalid;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (ld_fire) state_d = WAIT_LD;
      WAIT_LD: if (dmem_rvalid) state_d = ld_fire ? WAIT_LD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Choose what reaches the write port next cycle: load result first,
  // then a parked ALU op, then a freshly fired ALU op.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_rd_d   = rf_waddr;
    wr_data_d = rf_wdata;
    pend_take = 1'b0;
    if (load_done) begin
      wr_en_d   = ctx_q.we & (ctx_q.rd != '0);
      wr_rd_d   = ctx_q.rd;
      wr_data_d = ld_data;
      pend_take = alu_fire;
    end else if (pend_v_q) begin
      wr_en_d   = pend_we_q;
      wr_rd_d   = pend_rd_q;
      wr_data_d = pend_data_q;
      pend_take = alu_fire;
    end else if (alu_fire) begin
      wr_en_d   = m_we & (m_rd != '0);
      wr_rd_d   = m_rd;
      wr_data_d = m_alu_res;
    end
  end

  // State, load context, pending slot and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctx_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_rd_q   <= '0;
      pend_data_q <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      state_q  <= state_d;
      rf_we    <= wr_en_d;
      rf_waddr <= wr_rd_d;
      rf_wdata <= wr_data_d;
      pend_v_q <= pend_take;
      if (ld_fire) begin
        ctx_q.rd      <= m_rd;
        ctx_q.we      <= m_we;
        ctx_q.funct3  <= m_funct3;
        ctx_q.addr_lo <= m_addr_lo;
      end
      if (pend_take) begin
        pend_we_q   <= m_we & (m_rd != '0);
        pend_rd_q   <= m_rd;
        pend_data_q <= m_alu_res;
      end
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
  assign dbg_state = state_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;
  logic [1:0]  retire_cnt;

  assign retire_cnt = {1'b0, alu_fire} + {1'b0, load_done};

  // Retired-instruction counter: ALU ops count on fire, loads on rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_q + {62'd0, retire_cnt};
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage. Expected instret follows WB_INSTRET_EN.
`timescale 1ns/1ps
import wb_pkg::*;

module tb_wb_stage;

  logic        clk, rst_n;
  logic        m_valid, m_ready, m_we, m_is_load;
  logic [4:0]  m_rd;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu_res;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data;
  logic [63:0] instret;
  wb_state_t   dbg_state;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] exp_ir   = 0;

  wb_stage #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_we(m_we),
    .m_is_load(m_is_load), .m_funct3(m_funct3), .m_addr_lo(m_addr_lo),
    .m_alu_res(m_alu_res), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ir_exp();
`ifdef WB_INSTRET_EN
    return exp_ir;
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_valid     = 1'b0;
    m_rd        = '0;
    m_we        = 1'b0;
    m_is_load   = 1'b0;
    m_funct3    = '0;
    m_addr_lo   = '0;
    m_alu_res   = '0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic set_op(input logic [4:0] rd, input logic we, input logic is_load,
                        input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] res);
    m_valid   = 1'b1;
    m_rd      = rd;
    m_we      = we;
    m_is_load = is_load;
    m_funct3  = f3;
    m_addr_lo = alo;
    m_alu_res = res;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    check({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, we});
    check({tag, ".fwd_valid"}, {63'd0, fwd_valid}, {63'd0, we});
    if (we) begin
      check({tag, ".waddr"}, {59'd0, rf_waddr}, {59'd0, rd});
      check({tag, ".wdata"}, {32'd0, rf_wdata}, {32'd0, data});
      check({tag, ".fwd_rd"}, {59'd0, fwd_rd}, {59'd0, rd});
      check({tag, ".fwd_data"}, {32'd0, fwd_data}, {32'd0, data});
    end
  endtask

  // Driver: one ALU op, write checked the following cycle, then pulse end.
  task automatic do_alu(input string tag, input logic [4:0] rd, input logic we,
                        input logic [31:0] res);
    set_op(rd, we, 1'b0, 3'd0, 2'd0, res);
    #1 check({tag, ".m_ready"}, {63'd0, m_ready}, 64'd1);
    tick();
    idle_inputs();
    exp_ir++;
    check_wr(tag, we & (rd != 0), rd, res);
    check({tag, ".instret"}, instret, ir_exp());
    tick();
    check({tag, ".pulse"}, {63'd0, rf_we}, 64'd0);
  endtask

  // Driver: one load with `delay` empty wait cycles before rvalid.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] rdata, input int delay,
                         input logic [31:0] exp);
    set_op(rd, 1'b1, 1'b1, f3, alo, 32'h0);
    #1 check({tag, ".m_ready"}, {63'd0, m_ready}, 64'd1);
    tick();
    idle_inputs();
    check({tag, ".no_early_we"}, {63'd0, rf_we}, 64'd0);
    check({tag, ".state"}, {63'd0, dbg_state}, {63'd0, WAIT_LD});
    for (int i = 0; i < delay; i++) begin
      check({tag, ".wait_ready"}, {63'd0, m_ready}, 64'd0);
      tick();
      check({tag, ".wait_we"}, {63'd0, rf_we}, 64'd0);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1 check({tag, ".rv_ready"}, {63'd0, m_ready}, 64'd1);
    tick();
    idle_inputs();
    exp_ir++;
    check_wr(tag, 1'b1, rd, exp);
    check({tag, ".instret"}, instret, ir_exp());
    tick();
    check({tag, ".pulse"}, {63'd0, rf_we}, 64'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst.rf_we", {63'd0, rf_we}, 64'd0);
    check("rst.waddr", {59'd0, rf_waddr}, 64'd0);
    check("rst.wdata", {32'd0, rf_wdata}, 64'd0);
    check("rst.instret", instret, 64'd0);
    check("rst.state", {63'd0, dbg_state}, {63'd0, IDLE});
    check("rst.m_ready", {63'd0, m_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // ALU write and sub-word loads
    do_alu("alu_x5", 5'd5, 1'b1, 32'h1234_5678);
    do_load("lb_x7", 5'd7, F3_LB, 2'd3, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    do_load("lhu", 5'd8, F3_LHU, 2'd2, 32'hBEEF_1234, 0, 32'h0000_BEEF);
    do_load("lh", 5'd8, F3_LH, 2'd2, 32'hBEEF_1234, 1, 32'hFFFF_BEEF);
    do_load("lh_lo", 5'd12, F3_LH, 2'd1, 32'h0000_8001, 0, 32'hFFFF_8001);
    do_load("lbu", 5'd13, F3_LBU, 2'd1, 32'h1234_80AB, 0, 32'h0000_0080);
    do_load("lw", 5'd14, F3_LW, 2'd3, 32'h89AB_CDEF, 0, 32'h89AB_CDEF);
    do_load("f3_other", 5'd15, 3'd3, 2'd1, 32'h0102_0304, 0, 32'h0102_0304);

    // rd=0 and non-writing ops still retire
    do_alu("alu_x0", 5'd0, 1'b1, 32'hDEAD_BEEF);
    do_alu("alu_nowe", 5'd3, 1'b0, 32'h0000_0033);

    // Load completes while an ALU op is accepted the same cycle
    set_op(5'd10, 1'b1, 1'b1, F3_LW, 2'd0, 32'h0);
    tick();
    set_op(5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0099);
    #1 check("b2b.held_ready", {63'd0, m_ready}, 64'd0);
    tick();
    check("b2b.held_we", {63'd0, rf_we}, 64'd0);
    check("b2b.held_instret", instret, ir_exp());
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    #1 check("b2b.rv_ready", {63'd0, m_ready}, 64'd1);
    tick();
    idle_inputs();
    exp_ir += 2;
    check_wr("b2b.load", 1'b1, 5'd10, 32'hCAFE_F00D);
    check("b2b.instret", instret, ir_exp());
    tick();
    check_wr("b2b.alu", 1'b1, 5'd9, 32'h0000_0099);
    check("b2b.state", {63'd0, dbg_state}, {63'd0, IDLE});
    tick();
    check("b2b.pulse", {63'd0, rf_we}, 64'd0);

    // dmem_rvalid while idle is ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    tick();
    idle_inputs();
    check("idle_rv.we", {63'd0, rf_we}, 64'd0);
    check("idle_rv.instret", instret, ir_exp());

    // Reset while waiting for load data
    set_op(5'd11, 1'b1, 1'b1, F3_LW, 2'd0, 32'h0);
    tick();
    idle_inputs();
    check("rstw.state_pre", {63'd0, dbg_state}, {63'd0, WAIT_LD});
    #2 rst_n = 1'b0;
    exp_ir = 0;
    #1;
    check("rstw.state", {63'd0, dbg_state}, {63'd0, IDLE});
    check("rstw.waddr", {59'd0, rf_waddr}, 64'd0);
    check("rstw.wdata", {32'd0, rf_wdata}, 64'd0);
    check("rstw.instret", instret, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    tick();
    idle_inputs();
    check("rstw.no_write", {63'd0, rf_we}, 64'd0);
    check("rstw.state_post", {63'd0, dbg_state}, {63'd0, IDLE});
    check("rstw.m_ready", {63'd0, m_ready}, 64'd1);
    check("rstw.instret_post", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
